// File: rtl/hist_bin_collector.sv
// Receive-side collector for the histogram bin readout stream: buffers bins, sums them, flags bad frames.
// Optional peak tracking is enabled by defining HIST_PEAK_EN.
module hist_bin_collector #(
   parameter  int unsigned NUM_BINS = 16,
   parameter  int unsigned BIN_W    = 8,
   localparam int unsigned ADDR_W   = $clog2(NUM_BINS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      arm,
   input  logic [BIN_W-1:0]          bin_data,
   input  logic                      bin_valid,
   input  logic                      bin_last,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      frame_valid,
   output logic                      frame_err,
   output logic [ADDR_W:0]           bin_count,
   output logic [BIN_W+ADDR_W:0]     total,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [BIN_W-1:0]          rd_data,
   output logic [ADDR_W-1:0]         peak_idx,
   output logic [BIN_W-1:0]          peak_val
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] FULL = NUM_BINS[ADDR_W:0];

   state_t              state;
   state_t              state_next;
   logic [BIN_W-1:0]    mem [NUM_BINS];
   logic                clr;
   logic                beat;
   logic                full;
   logic                store;
   logic [ADDR_W:0]     count_next;
   logic [ADDR_W-1:0]   wr_idx;

   // arm is only honoured outside DONE; a beat in an arm cycle is always dropped
   assign clr        = arm && (state != DONE);
   assign beat       = (state == CAPTURE) && bin_valid && !arm;
   assign full       = (bin_count == FULL);
   assign store      = beat && !full && !reset;
   assign count_next = full ? bin_count : bin_count + 1'b1;
   assign wr_idx     = bin_count[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (arm) state_next = CAPTURE;
         end
         CAPTURE: begin
            busy = 1'b1;
            if (beat && bin_last) state_next = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_count   <= '0;
         total       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else if (clr) begin
         bin_count   <= '0;
         total       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else if (beat) begin
         if (!full) begin
            bin_count <= count_next;
            total     <= total + {{(ADDR_W+1){1'b0}}, bin_data};
         end else begin
            frame_err <= 1'b1;
         end
         if (bin_last && (count_next != FULL)) frame_err <= 1'b1;
      end else if (state == DONE) begin
         frame_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem[wr_idx] <= bin_data;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

`ifdef HIST_PEAK_EN
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         peak_idx <= '0;
         peak_val <= '0;
      end else if (store && (bin_data > peak_val)) begin
         peak_idx <= wr_idx;
         peak_val <= bin_data;
      end
   end
`else
   assign peak_idx = '0;
   assign peak_val = '0;
`endif

endmodule

// File: doc/hist_bin_collector.md
Name: hist_bin_collector

Overview:
Receive-side counterpart of the histogramming core's bin readout stream.
- Consumes the serial bin stream (bin value, valid, last-bin marker) emitted when the histogram is read out.
- Reassembles the bins into a local addressable buffer and computes the frame total.
- Flags malformed frames (too short, too long).
- Sits downstream of the histogram engine and presents a random-access read port plus completion/status to the host-side logic.

Parameters:
NUM_BINS, 16, bins per frame; power of two, 2..256
BIN_W, 8, width of one bin value
ADDR_W, $clog2(NUM_BINS), bin index width (derived, do not override)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
arm  input  1  start/restart capture of a new frame
bin_data  input  BIN_W  incoming bin value
bin_valid  input  1  bin_data is a valid beat this cycle
bin_last  input  1  current beat is the final bin of the frame (qualified by bin_valid)
busy  output  1  high while in CAPTURE
frame_done  output  1  one-cycle pulse on frame completion
frame_valid  output  1  level; buffer holds a completed frame; cleared by arm or reset
frame_err  output  1  sticky; frame was short or overflowed; cleared by arm or reset
bin_count  output  ADDR_W+1  bins stored in the current/last frame
total  output  BIN_W+ADDR_W+1  sum of stored bin values
rd_addr  input  ADDR_W  read address into bin buffer
rd_data  output  BIN_W  registered read data, 1-cycle latency
peak_idx  output  ADDR_W  index of largest bin (see Optional Feature)
peak_val  output  BIN_W  value of largest bin (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high. State=IDLE; all outputs 0, including rd_data, peak_idx and peak_val. Buffer contents undefined; rd_data is 0 on the first cycle after reset.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - bin_valid is ignored.
  - arm=1 -> CAPTURE next cycle. Same edge clears bin_count, total, frame_valid, frame_err, peak_*.
  - A beat presented in the arm cycle is dropped.
- CAPTURE (busy=1), on each bin_valid=1:
  - If bin_count<NUM_BINS: write mem[bin_count]=bin_data, bin_count+=1, total+=bin_data.
  - If bin_count==NUM_BINS (buffer full): discard the beat, set frame_err (overflow). bin_count and total unchanged.
  - If bin_last=1 on that beat: go to DONE. If the final stored count != NUM_BINS, set frame_err (short frame).
  - bin_valid=0 cycles are gaps: no state change.
  - bin_last with bin_valid=0 is ignored.
- DONE: lasts one cycle. frame_done=1, frame_valid<=1, return to IDLE.
  - frame_done is therefore asserted the cycle after the last beat is accepted.
- arm in CAPTURE: aborts the frame and restarts it. Counters, err and peak are cleared; stays in CAPTURE; the beat in that cycle is dropped.
- arm in DONE: ignored.
- total: plain unsigned add with no saturation; the width guarantees no wrap.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in any state.
  - Reads during CAPTURE return whatever is stored, which may be stale or mixed-frame.
  - Read and write to the same address in the same cycle returns the old value (read-before-write).
- reset mid-CAPTURE: IDLE next cycle, outputs cleared, no frame_done pulse.
- A reset asserted together with arm or bin_valid takes priority.

Optional Feature:
Macro HIST_PEAK_EN.
- Defined:
  - On each stored beat, if bin_data > peak_val, then peak_val<=bin_data and peak_idx<=store index.
  - Comparison is strict, so ties keep the lowest index.
  - A frame with all-zero bins gives peak_idx=0, peak_val=0.
  - Discarded overflow beats never update the peak.
- Undefined: peak_idx and peak_val are tied to 0, with no comparator or registers. The ports remain present.

Test Plan:
- Reset, arm, 16 beats with values 1..16, last on the 16th -> frame_done pulse 1 cycle after the 16th beat; frame_valid=1, frame_err=0, bin_count=16, total=136. rd_addr=5 -> rd_data=6 next cycle. With HIST_PEAK_EN: peak_idx=15, peak_val=16.
- Short frame: arm, 10 beats of value 3, last on the 10th -> frame_done, frame_err=1, bin_count=10, total=30, frame_valid=1.
- Overflow: arm, 20 beats of value 2, last on the 20th -> bin_count=16, total=32, frame_err=1; mem[15]=2; done one cycle after the 20th beat.
- Gaps and idle:
  - Beats with bin_valid=0 gaps between them give the same result as back-to-back beats.
  - 5 beats before arm are ignored (bin_count stays 0).
  - A beat in the arm cycle is dropped.
- Abort/reset:
  - After 7 beats, arm=1 -> bin_count=0, busy stays 1.
  - Separately, reset after 7 beats -> IDLE, all outputs 0, no frame_done; a following bin_valid is ignored.
- Peak tie (HIST_PEAK_EN): value 9 at indices 3 and 7, all others 1 -> peak_idx=3, peak_val=9.
  - Without the macro, peak_idx=0 and peak_val=0 always.
